pipelined_addsub: RTL and testbench
===================================

# pipelined_addsub

Parametrised, pipelined integer adder/subtractor for the execute datapath. Splits a WIDTH-bit ripple-carry add into STAGES registered carry segments so that only one segment length falls in each clock period. Supports add, subtract, add-with-carry and subtract-with-borrow, and produces carry, signed-overflow and zero flags. A valid/ready handshake carries each operation through the pipeline, so back-pressure stalls it without losing or duplicating results.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- STAGES, 4, number of register stages and carry segments. WIDTH % STAGES == 0 is required. Segment width is CW = WIDTH/STAGES.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- in_valid  input  1  operation presented.
- in_ready  output  1  pipeline can accept an operation this cycle.
- op  input  2  00 ADD (a+b), 01 SUB (a+~b+1), 10 ADC (a+b+cin), 11 SBC (a+~b+cin).
- cin  input  1  carry-in; used only for ADC/SBC.
- a, b  input  WIDTH  operands.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry  output  1  carry out of bit WIDTH-1. For SUB/SBC, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

## Operation
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Operand preparation at input: b' = b for ADD/ADC, ~b for SUB/SBC. c0 = 0 (ADD), 1 (SUB), cin (ADC/SBC).
- Stage k (k = 1..STAGES) computes segment k-1, i.e. bits [k*CW-1 : (k-1)*CW], as a CW-bit ripple add. Its carry-in is the carry registered by stage k-1, or c0 for k = 1.
- Stage k registers:
  - the completed low segments;
  - the still-unprocessed upper segments of a and b' (skew delay);
  - the segment carry-out;
  - a valid bit.
- The last stage also registers carry, overflow (from the MSB carry-in and carry-out of segment STAGES-1) and zero.
- Stall rule, per stage: a stage loads when it is empty or its current contents leave this cycle. The last stage leaves on out_ready. Stage k<STAGES leaves when stage k+1 loads.
- in_ready = stage 1 empty || stage 1 leaving. in_ready must not depend on in_valid.
- Bubbles collapse: an empty stage loads even while a downstream stage is stalled.
- A stage that is not loading holds all its data and valid bits unchanged.
- Results emerge in input order; no drop or duplication.
- STAGES = 1 degenerates to a single registered full-width add.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits clear; sum = 0, carry = 0, overflow = 0, zero = 0, out_valid = 0.
- in_ready is 1 from the first cycle after rst_n deasserts.
- A reset asserted mid-operation discards every in-flight operation. No partial result is ever presented.
- Latency: an operation accepted at edge t is presented with out_valid = 1 after edge t+STAGES-1, i.e. it is visible in the cycle following edge t+STAGES-1 when out_ready is held 1.
- Throughput: 1 operation/cycle while out_ready = 1.
- Pipeline full with out_ready = 0: in_ready = 0. Outputs hold stable until the transfer.
- Full pipeline, out_ready = 1, in_valid = 1: accept and emit in the same cycle, no bubble.
- sum, carry, overflow and zero are undefined-free but don't-care while out_valid = 0. They must change only on an output-stage load.

## Test plan
- Defaults (32/4), ADD a=0xFFFFFFFF b=0x00000001, out_ready=1 -> sum 0x00000000, carry 1, zero 1, overflow 0; out_valid exactly 4 cycles after acceptance.
- SUB a=5 b=7 -> sum 0xFFFFFFFE, carry 0 (borrow), overflow 0, zero 0. SUB a=0x80000000 b=1 -> 0x7FFFFFFF, overflow 1, carry 1.
- ADD 0x7FFFFFFF+1 -> 0x80000000, overflow 1, carry 0. ADC a=0x000000FF b=0 cin=1 -> 0x00000100, exercising the carry across the segment boundary. SBC a=0 b=0 cin=0 -> 0xFFFFFFFF, carry 0.
- Stream of 16 random ops with in_valid=1 and out_ready toggled pseudo-randomly (include 6 consecutive low cycles) -> results match a reference model in order. No loss or duplication. in_ready=0 only when all 4 stages are full and out_ready=0. Outputs stable while stalled.
- Reset mid-stream with 3 ops in flight -> all outputs 0 and out_valid 0 immediately (asynchronous). After release, no stale result appears. The next op returns correctly with 4-cycle latency.
- Sweep STAGES ∈ {1, 2, 8} at WIDTH=32 and WIDTH=8/STAGES=2 with the directed vectors above scaled to width -> flags and sum correct, latency = STAGES.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: the carry chain is cut into STAGES registered
// CW-bit ripple segments. Operands skew through the pipe alongside the partial sum.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  // WIDTH must be a multiple of STAGES; each stage owns one CW-bit segment.
  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is a pure function of pipeline occupancy and out_ready, never of
  // in_valid; out_valid/sum/flags stay frozen until the consumer takes them.

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  a_d  [STAGES];
  logic [WIDTH-1:0]  bp_q [STAGES];
  logic [WIDTH-1:0]  bp_d [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [STAGES-1:0] src_v, src_c;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [WIDTH-1:0]  s_new [STAGES];
  logic [STAGES-1:0] c_new;
  logic [STAGES-1:0] ld, en;
  logic [WIDTH-1:0]  b_prep;
  logic              c0;
  logic              rc, msb_cin;
  logic              ovf_new, zero_new;

  always_comb begin
    b_prep = op[0] ? ~b : b;
    unique case (op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      default: c0 = cin;
    endcase
  end

  // Each stage is fed from the previous stage's registers, stage 0 from the ports.
  always_comb begin
    src_v    = '0;
    src_c    = '0;
    src_v[0] = in_valid;
    src_c[0] = c0;
    src_a[0] = a;
    src_b[0] = b_prep;
    src_s[0] = '0;
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = v_q[i-1];
      src_c[i] = c_q[i-1];
      src_a[i] = a_q[i-1];
      src_b[i] = bp_q[i-1];
      src_s[i] = s_q[i-1];
    end
  end

  always_comb begin
    rc       = 1'b0;
    msb_cin  = 1'b0;
    c_new    = '0;
    for (int i = 0; i < STAGES; i++) begin
      s_new[i] = src_s[i];
      rc       = src_c[i];
      for (int j = 0; j < CW; j++) begin
        if (i == LAST && j == CW - 1) msb_cin = rc;
        s_new[i][i*CW+j] = src_a[i][i*CW+j] ^ src_b[i][i*CW+j] ^ rc;
        rc = (src_a[i][i*CW+j] & src_b[i][i*CW+j]) |
             (rc & (src_a[i][i*CW+j] ^ src_b[i][i*CW+j]));
      end
      c_new[i] = rc;
    end
    ovf_new  = msb_cin ^ c_new[LAST];
    zero_new = (s_new[LAST] == '0);
  end

  // A stage loads when empty or when its occupant moves on; this also lets
  // bubbles collapse behind a stalled output stage.
  always_comb begin
    ld       = '0;
    ld[LAST] = ~v_q[LAST] | out_ready;
    for (int i = LAST - 1; i >= 0; i--) begin
      ld[i] = ~v_q[i] | ld[i+1];
    end
    en  = ld & src_v;
    v_d = v_q;
    for (int i = 0; i < STAGES; i++) begin
      if (ld[i]) v_d[i] = src_v[i];
    end
  end

  always_comb begin
    c_d    = c_q;
    ovf_d  = en[LAST] ? ovf_new  : ovf_q;
    zero_d = en[LAST] ? zero_new : zero_q;
    for (int i = 0; i < STAGES; i++) begin
      a_d[i]  = en[i] ? src_a[i] : a_q[i];
      bp_d[i] = en[i] ? src_b[i] : bp_q[i];
      s_d[i]  = en[i] ? s_new[i] : s_q[i];
      if (en[i]) c_d[i] = c_new[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i]  <= '0;
        bp_q[i] <= '0;
        s_q[i]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i]  <= a_d[i];
        bp_q[i] <= bp_d[i];
        s_q[i]  <= s_d[i];
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign carry     = c_q[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed table, random back-pressured stream with
// an expected queue, asynchronous reset mid-stream, and a WIDTH/STAGES sweep.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_sum;
    logic        e_c;
    logic        e_v;
    logic        e_z;
  } vec_t;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready;
  logic        carry, overflow, zero;
  logic [1:0]  op;
  logic [31:0] a, b, sum;
  logic [34:0] exp_q[$];
  vec_t        vt[8];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cin(cin), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow),
    .zero(zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; overflow is "signed result out of range".
  function automatic res_t ref_model(input int w, input logic [1:0] o, input logic c,
                                     input logic [63:0] x, input logic [63:0] y);
    res_t        r;
    logic [63:0] mask, xa, yb, full;
    longint      sx, sy, sres, lim;
    mask = (64'd1 << w) - 64'd1;
    xa   = x & mask;
    yb   = y & mask;
    sx   = xa[w-1] ? longint'(xa) - (longint'(1) <<< w) : longint'(xa);
    sy   = yb[w-1] ? longint'(yb) - (longint'(1) <<< w) : longint'(yb);
    lim  = longint'(1) <<< (w - 1);
    case (o)
      2'b00: begin full = xa + yb;                               sres = sx + sy;             end
      2'b01: begin full = xa + (~yb & mask) + 64'd1;             sres = sx - sy;             end
      2'b10: begin full = xa + yb + {63'd0, c};                  sres = sx + sy + longint'(c); end
      default: begin full = xa + (~yb & mask) + {63'd0, c};      sres = sx - sy - 1 + longint'(c); end
    endcase
    r.sum   = full & mask;
    r.carry = full[w];
    r.ovf   = (sres >= lim) || (sres < -lim);
    r.zero  = (r.sum == 64'd0);
    return r;
  endfunction

  function automatic void dir_vec(input int idx, input int w, output logic [1:0] o,
                                  output logic c, output logic [63:0] x, output logic [63:0] y);
    logic [63:0] one;
    one = 64'd1;
    o = 2'b00; c = 1'b0; x = 64'd0; y = 64'd0;
    case (idx)
      0: begin o = 2'b00; x = (one << w) - one; y = 64'd1; end
      1: begin o = 2'b01; x = 64'd5; y = 64'd7; end
      2: begin o = 2'b01; x = one << (w - 1); y = 64'd1; end
      3: begin o = 2'b00; x = (one << (w - 1)) - one; y = 64'd1; end
      4: begin o = 2'b10; x = (w > 8) ? 64'hFF : 64'h0F; y = 64'd0; c = 1'b1; end
      default: begin o = 2'b11; x = 64'd0; y = 64'd0; c = 1'b0; end
    endcase
  endfunction

  task automatic run_one(input logic [1:0] o, input logic c, input logic [31:0] x,
                         input logic [31:0] y, output int lat);
    @(negedge clk);
    op = o; cin = c; a = x; b = y; out_ready = 1'b1; in_valid = 1'b1;
    #1 chk("accept in_ready", in_ready, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Width/depth sweep: each configuration runs the directed vectors scaled to its width.
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = (g == 3) ? 8 : 32;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 2;
    logic         g_rst_n, g_in_valid, g_in_ready, g_cin, g_out_valid, g_out_ready;
    logic         g_carry, g_ovf, g_zero;
    logic [1:0]   g_op;
    logic [W-1:0] g_a, g_b, g_sum;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_sweep (
      .clk(clk), .rst_n(g_rst_n), .in_valid(g_in_valid), .in_ready(g_in_ready),
      .op(g_op), .cin(g_cin), .a(g_a), .b(g_b), .out_valid(g_out_valid),
      .out_ready(g_out_ready), .sum(g_sum), .carry(g_carry), .overflow(g_ovf),
      .zero(g_zero)
    );

    initial begin
      int          lat;
      res_t        r;
      logic [1:0]  vo;
      logic        vc;
      logic [63:0] vx, vy;
      string       tag;
      g_rst_n = 1'b0; g_in_valid = 1'b0; g_out_ready = 1'b1;
      g_op = 2'b00; g_cin = 1'b0; g_a = '0; g_b = '0;
      repeat (2) @(negedge clk);
      g_rst_n = 1'b1;
      for (int v = 0; v < 6; v++) begin
        dir_vec(v, W, vo, vc, vx, vy);
        r   = ref_model(W, vo, vc, vx, vy);
        tag = $sformatf("W%0d_S%0d_v%0d", W, S, v);
        @(negedge clk);
        g_op = vo; g_cin = vc; g_a = vx[W-1:0]; g_b = vy[W-1:0]; g_in_valid = 1'b1;
        #1 chk({tag, " in_ready"}, g_in_ready, 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        g_in_valid = 1'b0;
        while (!g_out_valid && lat < 40) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end
        chk({tag, " latency"}, lat, S);
        chk({tag, " sum"}, g_sum, r.sum);
        chk({tag, " carry"}, g_carry, r.carry);
        chk({tag, " overflow"}, g_ovf, r.ovf);
        chk({tag, " zero"}, g_zero, r.zero);
      end
      done_cnt++;
    end
  end

  initial begin
    int          lat, sent, recv;
    logic [1:0]  p_op;
    logic        p_cin;
    logic [31:0] p_a, p_b;
    logic [34:0] e;
    res_t        r;

    vt[0] = '{2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[1] = '{2'b01, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[2] = '{2'b01, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[3] = '{2'b00, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[4] = '{2'b10, 1'b1, 32'h000000FF, 32'h00000000, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vt[5] = '{2'b11, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vt[6] = '{2'b01, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[7] = '{2'b00, 1'b1, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0};

    // Clock/reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset sum", sum, 0);
    chk("reset carry", carry, 0);
    chk("reset overflow", overflow, 0);
    chk("reset zero", zero, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_one(vt[i].op, vt[i].cin, vt[i].a, vt[i].b, lat);
      chk($sformatf("vec%0d latency", i), lat, 4);
      chk($sformatf("vec%0d sum", i), sum, vt[i].e_sum);
      chk($sformatf("vec%0d carry", i), carry, vt[i].e_c);
      chk($sformatf("vec%0d overflow", i), overflow, vt[i].e_v);
      chk($sformatf("vec%0d zero", i), zero, vt[i].e_z);
    end

    // Random stream under back-pressure, scored against the expected queue
    sent = 0; recv = 0;
    exp_q.delete();
    p_op = 2'($urandom_range(0, 3)); p_cin = 1'($urandom_range(0, 1));
    p_a = $urandom(); p_b = $urandom();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (recv == 16) break;
      @(negedge clk);
      out_ready = (cyc >= 4 && cyc < 10) ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid  = (sent < 16);
      op = p_op; cin = p_cin; a = p_a; b = p_b;
      #1;
      chk("stream in_ready", in_ready, (exp_q.size() < 4) || out_ready);
      if (exp_q.size() == 0) begin
        chk("stream idle out_valid", out_valid, 0);
      end else if (out_valid) begin
        e = exp_q[0];
        chk("stream sum", sum, e[31:0]);
        chk("stream carry", carry, e[34]);
        chk("stream overflow", overflow, e[33]);
        chk("stream zero", zero, e[32]);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        recv++;
      end
      if (in_valid && in_ready) begin
        r = ref_model(32, p_op, p_cin, {32'd0, p_a}, {32'd0, p_b});
        exp_q.push_back({r.carry, r.ovf, r.zero, r.sum[31:0]});
        sent++;
        p_op = 2'($urandom_range(0, 3)); p_cin = 1'($urandom_range(0, 1));
        p_a = $urandom(); p_b = $urandom();
      end
    end
    chk("stream sent count", sent, 16);
    chk("stream recv count", recv, 16);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("stream drained out_valid", out_valid, 0);

    // Asynchronous reset with three operations in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      op = 2'b00; cin = 1'b0; a = 32'h100 + k; b = 32'h1;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("pre-reset out_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset sum", sum, 0);
    chk("async reset carry", carry, 0);
    chk("async reset overflow", overflow, 0);
    chk("async reset zero", zero, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 chk("no stale result", out_valid, 0);
    end
    run_one(2'b00, 1'b0, 32'h12345678, 32'h11111111, lat);
    chk("after reset latency", lat, 4);
    chk("after reset sum", sum, 32'h23456789);
    chk("after reset carry", carry, 0);
    chk("after reset zero", zero, 0);

    for (int k = 0; k < 2000; k++) begin
      if (done_cnt == 4) break;
      @(posedge clk);
    end
    chk("sweep completion", done_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
